// File: rtl/ripple_count_capture_if.sv
// ----------------------------------------------------------------------------
// ripple_count_capture_if
// Purpose : valid/ready event bus carrying one accepted count sample from
//           ripple_count_capture to its downstream consumer.
// Signals :
//   valid - an accepted count event is held on the bus
//   data  - accepted 4-bit count value
//   dir   - synchronized counter direction at acceptance (1 = up)
//   wrap  - event crossed the 15/0 boundary in the direction of dir
//   skip  - event step was not exactly one count in the direction of dir
//   ready - consumer accepts the held event this cycle
// Modports: master (the capture block), slave (the consumer)
// ----------------------------------------------------------------------------
interface ripple_count_capture_if;
  logic       valid;
  logic [3:0] data;
  logic       dir;
  logic       wrap;
  logic       skip;
  logic       ready;

  modport master (output valid, data, dir, wrap, skip, input ready);
  modport slave  (input valid, data, dir, wrap, skip, output ready);
endinterface

// File: rtl/ripple_count_capture.sv
// ----------------------------------------------------------------------------
// ripple_count_capture
// Purpose : samples the outputs of an asynchronous 4-bit ripple up/down
//           counter, filters ripple glitches, and reports each settled new
//           count as a single event through a one-entry valid/ready buffer.
// Parameters:
//   STABLE_CYCLES - consecutive identical synchronized samples needed before
//                   a value is accepted (2..15)
// Ports :
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   q_in    - asynchronous count value from the ripple counter
//   mode_in - asynchronous direction of that counter (1 = up, 0 = down)
//   ovf     - sticky: an event was dropped because the buffer was full
//   bus     - master side of the event bus (valid/data/dir/wrap/skip/ready)
// ----------------------------------------------------------------------------
module ripple_count_capture #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   q_in,
  input  logic                         mode_in,
  output logic                         ovf,
  ripple_count_capture_if.master       bus
);

  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_M1  = 4'(STABLE_CYCLES - 1);

  // Synchronizer stages
  logic [3:0] q_s1_q, q_s1_d, q_s2_q, q_s2_d;
  logic       mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;

  // Glitch filter
  logic [3:0] cand_q, cand_d;
  logic [3:0] run_q, run_d;
  logic [3:0] acc_q, acc_d;

  // Output buffer
  logic       valid_q, valid_d;
  logic [3:0] data_q, data_d;
  logic       dir_q, dir_d;
  logic       wrap_q, wrap_d;
  logic       skip_q, skip_d;
  logic       ovf_q, ovf_d;

  // Event qualification
  logic       commit;
  logic [3:0] delta;
  logic       ev_wrap;
  logic       ev_skip;
  logic       load;

  // Two-flop synchronizers: straight wires between stages so each bit gets
  // a full cycle to resolve metastability.
  assign q_s1_d    = q_in;
  assign q_s2_d    = q_s1_q;
  assign mode_s1_d = mode_in;
  assign mode_s2_d = mode_s1_q;

  // A value commits exactly once: on the cycle its run reaches STABLE-1,
  // and only if it differs from what was last accepted (a glitch that
  // settles back to acc is silently absorbed).
  assign commit = (q_s2_q == cand_q) && (run_q == STABLE_M1) && (q_s2_q != acc_q);

  // Modulo-16 step from the previously accepted value.
  assign delta  = q_s2_q - acc_q;

  assign ev_wrap = mode_s2_q ? ((acc_q == 4'hF) && (q_s2_q == 4'h0))
                             : ((acc_q == 4'h0) && (q_s2_q == 4'hF));
  assign ev_skip = mode_s2_q ? (delta != 4'h1) : (delta != 4'hF);

  // The buffer can take a new event when empty or being drained this cycle.
  assign load = commit && (!valid_q || bus.ready);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cand_d  = cand_q;
    run_d   = run_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    data_d  = data_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;
    skip_d  = skip_q;
    ovf_d   = ovf_q;

    if (q_s2_q != cand_q) begin
      cand_d = q_s2_q;
      run_d  = 4'd1;
    end else if (run_q < STABLE_MAX) begin
      run_d  = run_q + 4'd1;
    end

    // acc tracks the counter even when the event itself is dropped.
    if (commit) begin
      acc_d = q_s2_q;
    end

    if (load) begin
      valid_d = 1'b1;
      data_d  = q_s2_q;
      dir_d   = mode_s2_q;
      wrap_d  = ev_wrap;
      skip_d  = ev_skip;
    end else if (commit) begin
      ovf_d   = 1'b1;
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      q_s1_q    <= '0;
      q_s2_q    <= '0;
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
      cand_q    <= '0;
      run_q     <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      dir_q     <= 1'b0;
      wrap_q    <= 1'b0;
      skip_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      q_s1_q    <= q_s1_d;
      q_s2_q    <= q_s2_d;
      mode_s1_q <= mode_s1_d;
      mode_s2_q <= mode_s2_d;
      cand_q    <= cand_d;
      run_q     <= run_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      skip_q    <= skip_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.valid = valid_q;
  assign bus.data  = data_q;
  assign bus.dir   = dir_q;
  assign bus.wrap  = wrap_q;
  assign bus.skip  = skip_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/ripple_count_capture.md
RIPPLE_COUNT_CAPTURE -- requirements
Module: ripple_count_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2, number of consecutive identical synchronized samples required before a count value is accepted; legal range 2..15.
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port q_in  input  4  asynchronous count value from the upstream ripple up/down counter.
REQ-005 SHALL have port mode_in  input  1  asynchronous direction select of that counter (1 = up, 0 = down).
REQ-006 SHALL have port ready  input  1  downstream consumer accepts the held event this cycle.
REQ-007 SHALL have port valid  output  1  an accepted count event is held on the outputs.
REQ-008 SHALL have port data  output  4  accepted count value.
REQ-009 SHALL have port dir  output  1  synchronized mode at acceptance time.
REQ-010 SHALL have port wrap  output  1  event crossed the 15/0 boundary in the direction of dir.
REQ-011 SHALL have port skip  output  1  event step was not exactly one count in the direction of dir.
REQ-012 SHALL have port ovf  output  1  sticky: an event was dropped because the output buffer was full.

Function
REQ-013 SHALL pass q_in and mode_in each through a two-flop synchronizer (s1, s2) with no logic between flops.
REQ-014 SHALL hold a candidate register cand[3:0] and run-length counter run: if s2 != cand then cand <= s2, run <= 1; else if run < STABLE_CYCLES then run <= run + 1.
REQ-015 SHALL accept a value (commit) in the cycle where s2 == cand, run == STABLE_CYCLES-1 and s2 != acc, acc being the last accepted value.
REQ-016 SHALL, on commit, update acc <= s2 and compute delta = (s2 - acc) mod 16 using the pre-update acc.
REQ-017 SHALL set wrap on commit when (dir=1, acc=15, s2=0) or (dir=0, acc=0, s2=15); else 0.
REQ-018 SHALL set skip on commit when dir=1 and delta != 1, or dir=0 and delta != 15; else 0.
REQ-019 SHALL give latency: a q_in change held steady causes valid to rise after the (STABLE_CYCLES+2)th rising clk edge, counting the first edge that samples the new value.
REQ-020 SHALL filter ripple glitches: any s2 value persisting fewer than STABLE_CYCLES cycles is never committed.
REQ-021 SHALL implement a one-entry output buffer: on commit with buffer empty, or with valid && ready in the same cycle, load data/dir/wrap/skip and assert valid next cycle.
REQ-022 SHALL hold data, dir, wrap and skip stable while valid=1 and ready=0.
REQ-023 SHALL clear valid on valid && ready with no simultaneous commit.
REQ-024 SHALL, on commit with valid=1 and ready=0, drop the event, still update acc, and set ovf=1; ovf stays set until reset.
REQ-025 SHALL ignore ready while valid=0.
REQ-026 SHALL not commit a return to the value already in acc (for example, a glitch that settles back).

Reset
REQ-027 SHALL, while rst=1 at a rising edge, clear s1, s2, cand, run, acc to 0 and valid, data, dir, wrap, skip, ovf to 0.
REQ-028 SHALL let rst take priority over commit and handshake; an event held or in flight when rst asserts is discarded and not reported after reset.
REQ-029 SHALL treat acc=0 after reset as matching the upstream counter reset value, so a steady q_in=0 produces no event.

Verification
REQ-030 Reset then q_in 0->1, mode_in=1, ready=1 -> valid pulses one cycle on the 4th edge; data=1, dir=1, wrap=0, skip=0.
REQ-031 acc=15, mode_in=1, q_in 15->0 -> data=0, wrap=1, skip=0; mode_in=0, q_in 0->15 from acc=0 -> wrap=1, dir=0.
REQ-032 q_in 3->2 (1 cycle)->0 (1 cycle)->4 steady with acc=3, mode up -> single event data=4, skip=0; the 2 and 0 glitches are never reported.
REQ-033 ready=0, two events 1 then 2 -> valid held with data=1, ovf=1 after the second commit; later ready=1 -> data=1 consumed, no event for 2.
REQ-034 valid=1, ready=1 in the same cycle as a commit of value 6 -> valid stays 1 and data=6 next cycle, ovf=0.
REQ-035 rst asserted one cycle while valid=1 and a new q_in is settling -> all outputs 0 next cycle; a subsequent steady q_in=0 yields no event.
